// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, reset defaults, next-PC select
// encoding and small address helpers.
package mips_pkg;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEQ        = 3'd0,
        BRANCH     = 3'd1,
        JUMP       = 3'd2,
        HOLD       = 3'd3,
        EARLY_JUMP = 3'd4
    } next_pc_sel_t;

    // Targets are word addresses; the two low bits are never honoured.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] j_target(input logic [31:0] pc4,
                                             input logic [31:0] instr);
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// Bubble has priority over load; neither asserted holds the contents.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] fetched_instr,
    input  logic [31:0] fetched_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [31:0] instr_r;
    logic [31:0] pc4_r;
    logic        valid_r;

    // IF/ID storage: reset, bubble insertion, load or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= NOP_INSTR;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (bubble) begin
            instr_r <= NOP_INSTR;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (load) begin
            instr_r <= fetched_instr;
            pc4_r   <= fetched_pc4;
            valid_r <= 1'b1;
        end else begin
            instr_r <= instr_r;
            pc4_r   <= pc4_r;
            valid_r <= valid_r;
        end
    end

    assign instr = instr_r;
    assign pc4   = pc4_r;
    assign valid = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, next-PC selection, halt detect and IF/ID.
// Optional macro FETCH_JUMP_EARLY_EN enables zero-bubble j predecode in IF.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    logic [31:0]  pc_r;
    logic [31:0]  fetch_count_r;
    logic [31:0]  pc4_s;
    logic [31:0]  next_pc_s;
    logic         halted_s;
    logic         redirect_s;
    logic         early_jump_s;
    logic         ifid_load_s;
    logic         ifid_bubble_s;
    next_pc_sel_t sel_s;

    // Halt detect, redirect summary and optional j predecode.
    always_comb begin
        pc4_s        = pc_r + 32'd4;
        halted_s     = (pc_r >= PC_LIMIT);
        redirect_s   = branch_taken | jump_taken;
        early_jump_s = 1'b0;
`ifdef FETCH_JUMP_EARLY_EN
        if (!redirect_s && !stall && !halted_s && (imem_instr[31:26] == OP_J)) begin
            early_jump_s = 1'b1;
        end else begin
            early_jump_s = 1'b0;
        end
`endif
    end

    // Next-PC source priority; a redirect beats a simultaneous stall.
    always_comb begin
        sel_s = SEQ;
        if (branch_taken) begin
            sel_s = BRANCH;
        end else if (jump_taken) begin
            sel_s = JUMP;
        end else if (stall || halted_s) begin
            sel_s = HOLD;
        end else if (early_jump_s) begin
            sel_s = EARLY_JUMP;
        end else begin
            sel_s = SEQ;
        end
    end

    // Next-PC mux.
    always_comb begin
        next_pc_s = pc4_s;
        case (sel_s)
            BRANCH:     next_pc_s = word_align(branch_target);
            JUMP:       next_pc_s = word_align(jump_target);
            HOLD:       next_pc_s = pc_r;
            EARLY_JUMP: next_pc_s = j_target(pc4_s, imem_instr);
            SEQ:        next_pc_s = pc4_s;
            default:    next_pc_s = pc4_s;
        endcase
    end

    // A stalled halt keeps IF/ID frozen rather than bubbling it.
    always_comb begin
        ifid_bubble_s = redirect_s | (~stall & halted_s);
        ifid_load_s   = ~redirect_s & ~stall & ~halted_s;
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Count of valid instructions entering IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= 32'h0000_0000;
        end else if (ifid_load_s) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    if_id_reg u_if_id_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (ifid_load_s),
        .bubble        (ifid_bubble_s),
        .fetched_instr (imem_instr),
        .fetched_pc4   (pc4_s),
        .instr         (ifid_instr),
        .pc4           (ifid_pc4),
        .valid         (ifid_valid)
    );

    assign pc          = pc_r;
    assign imem_addr   = pc_r;
    assign halted      = halted_s;
    assign fetch_count = fetch_count_r;

endmodule
